// File: rtl/uart_div_ctrl.sv
// Byte-stream divide controller: gathers dividend/divisor from the UART receiver,
// runs a bit-serial restoring divider and streams quotient then remainder out.
module uart_div_ctrl #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 416640,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       err_div0,
  output logic       frame_drop
);

  localparam int NB     = DATA_W / 8;
  localparam int NBYTES = 2 * NB;
  localparam int BC_W   = $clog2(NBYTES + 1);
  localparam int IT_W   = $clog2(DATA_W);
  localparam int TXC_W  = $clog2(NBYTES);

  localparam logic [BC_W-1:0]  FULL_CNT = BC_W'(NBYTES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IT_W-1:0]  LAST_IT  = IT_W'(DATA_W - 1);
  localparam logic [TXC_W-1:0] LAST_TX  = TXC_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_RX, S_DIV, S_TX} state_t;

  state_t              state_q;
  logic [BC_W-1:0]     byte_cnt_q;
  logic [CNT_W-1:0]    tmo_q;
  logic [2*DATA_W-1:0] op_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [IT_W-1:0]     iter_q;
  logic [2*DATA_W-1:0] txbuf_q;
  logic [TXC_W-1:0]    tx_cnt_q;
  logic                tx_valid_q;
  logic [7:0]          tx_data_q;
  logic                busy_q;
  logic                err_q;
  logic                drop_q;

  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W:0]     trial;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;
  logic                tmo_hit;

  assign dividend = op_q[2*DATA_W-1:DATA_W];
  assign divisor  = op_q[DATA_W-1:0];

  // quo_q starts as the dividend and shifts left; quotient bits enter at the LSB.
  // When q_bit is set the true difference is below the divisor, so the low
  // DATA_W bits of the subtraction are exact.
  always_comb begin
    trial = {rem_q, quo_q[DATA_W-1]};
    q_bit = (trial >= {1'b0, divisor});
    rem_d = q_bit ? (trial[DATA_W-1:0] - divisor) : trial[DATA_W-1:0];
    quo_d = {quo_q[DATA_W-2:0], q_bit};
  end

  assign tmo_hit = (byte_cnt_q != '0) && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RX;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      iter_q     <= '0;
      txbuf_q    <= '0;
      tx_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_RX: begin
          if (byte_cnt_q == FULL_CNT) begin
            state_q    <= S_DIV;
            busy_q     <= 1'b1;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            rem_q      <= '0;
            quo_q      <= dividend;
            iter_q     <= '0;
            err_q      <= (divisor == '0);
          end else begin
            if (tmo_hit) drop_q <= 1'b1;
            if (rx_valid) begin
              op_q  <= {op_q[2*DATA_W-9:0], rx_data};
              tmo_q <= '0;
              // A byte coinciding with the timeout opens a new frame.
              if (tmo_hit || byte_cnt_q == '0) begin
                byte_cnt_q <= BC_W'(1);
                err_q      <= 1'b0;
              end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end else if (tmo_hit) begin
              byte_cnt_q <= '0;
              tmo_q      <= '0;
            end else if (byte_cnt_q != '0) begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        S_DIV: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          iter_q <= iter_q + 1'b1;
          if (iter_q == LAST_IT) begin
            state_q    <= S_TX;
            tx_valid_q <= 1'b1;
            tx_data_q  <= quo_d[DATA_W-1 -: 8];
            txbuf_q    <= {quo_d, rem_d} << 8;
            tx_cnt_q   <= '0;
          end
        end
        S_TX: begin
          if (tx_ready) begin
            if (tx_cnt_q == LAST_TX) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= S_RX;
            end else begin
              tx_cnt_q  <= tx_cnt_q + 1'b1;
              tx_data_q <= txbuf_q[2*DATA_W-1 -: 8];
              txbuf_q   <= txbuf_q << 8;
            end
          end
        end
        default: state_q <= S_RX;
      endcase
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign err_div0   = err_q;
  assign frame_drop = drop_q;

endmodule

// File: tb/tb_uart_div_ctrl.sv
// Scoreboard bench for uart_div_ctrl: 16-bit and 24-bit instances side by side.
module tb_uart_div_ctrl;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_rx_valid = 1'b0;
  logic [7:0] a_rx_data  = 8'h00;
  logic       a_tx_ready = 1'b1;
  logic       a_tx_valid, a_busy, a_err, a_drop;
  logic [7:0] a_tx_data;

  logic       b_rx_valid = 1'b0;
  logic [7:0] b_rx_data  = 8'h00;
  logic       b_tx_ready = 1'b1;
  logic       b_tx_valid, b_busy, b_err, b_drop;
  logic [7:0] b_tx_data;

  uart_div_ctrl #(.DATA_W(16), .TIMEOUT_CYC(TMO), .CNT_W(20)) u_a (
    .clk(clk), .rst(rst), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .tx_ready(a_tx_ready), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
    .busy(a_busy), .err_div0(a_err), .frame_drop(a_drop));

  uart_div_ctrl #(.DATA_W(24), .TIMEOUT_CYC(TMO), .CNT_W(20)) u_b (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .tx_ready(b_tx_ready), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .busy(b_busy), .err_div0(b_err), .frame_drop(b_drop));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int a_drops = 0;
  int a_rdy_mode = 1;  // 0 = hold low, 1 = always ready, 2 = random 30%

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (a_rdy_mode)
      0: a_tx_ready = 1'b0;
      1: a_tx_ready = 1'b1;
      default: a_tx_ready = ($urandom_range(0, 9) < 3);
    endcase
  end

  // Output monitors: hold-stability check plus scoreboard pop on each transfer.
  logic a_pv = 1'b0, a_pr = 1'b0;
  logic [7:0] a_pd = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      a_pv <= 1'b0;
    end else begin
      if (a_tx_valid && a_pv && !a_pr) chk("a_hold", a_tx_data, a_pd);
      if (a_tx_valid && a_tx_ready) begin
        if (exp_a.size() == 0) chk("a_unexpected_byte", exp_a.size(), 1);
        else begin
          chk("a_tx_byte", a_tx_data, exp_a[0]);
          $display("[TB] A tx byte %02h", a_tx_data);
          void'(exp_a.pop_front());
        end
      end
      if (a_drop) a_drops++;
      a_pv <= a_tx_valid;
      a_pr <= a_tx_ready;
      a_pd <= a_tx_data;
    end
  end

  always @(negedge clk) begin
    if (rst && b_tx_valid && b_tx_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected_byte", exp_b.size(), 1);
      else begin
        chk("b_tx_byte", b_tx_data, exp_b[0]);
        $display("[TB] B tx byte %02h", b_tx_data);
        void'(exp_b.pop_front());
      end
    end
  end

  task automatic rx_a(input logic [7:0] b);
    a_rx_data = b; a_rx_valid = 1'b1;
    @(posedge clk); #1;
    a_rx_valid = 1'b0;
  endtask

  task automatic rx_b(input logic [7:0] b);
    b_rx_data = b; b_rx_valid = 1'b1;
    @(posedge clk); #1;
    b_rx_valid = 1'b0;
  endtask

  task automatic push_a(input logic [15:0] dvd, input logic [15:0] dvs);
    logic [15:0] q, r;
    q = (dvs == 0) ? 16'hFFFF : dvd / dvs;
    r = (dvs == 0) ? dvd : dvd % dvs;
    exp_a.push_back(q[15:8]); exp_a.push_back(q[7:0]);
    exp_a.push_back(r[15:8]); exp_a.push_back(r[7:0]);
  endtask

  task automatic send_a(input logic [15:0] dvd, input logic [15:0] dvs);
    push_a(dvd, dvs);
    rx_a(dvd[15:8]); rx_a(dvd[7:0]); rx_a(dvs[15:8]); rx_a(dvs[7:0]);
  endtask

  task automatic send_b(input logic [23:0] dvd, input logic [23:0] dvs);
    logic [23:0] q, r;
    q = (dvs == 0) ? 24'hFFFFFF : dvd / dvs;
    r = (dvs == 0) ? dvd : dvd % dvs;
    exp_b.push_back(q[23:16]); exp_b.push_back(q[15:8]); exp_b.push_back(q[7:0]);
    exp_b.push_back(r[23:16]); exp_b.push_back(r[15:8]); exp_b.push_back(r[7:0]);
    rx_b(dvd[23:16]); rx_b(dvd[15:8]); rx_b(dvd[7:0]);
    rx_b(dvs[23:16]); rx_b(dvs[15:8]); rx_b(dvs[7:0]);
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 400 && exp_a.size() != 0; i++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_drain"}, exp_a.size(), 0);
    chk({tag, "_idle_valid"}, a_tx_valid, 1'b0);
    chk({tag, "_idle_busy"}, a_busy, 1'b0);
  endtask

  // Called right after the last rx byte: cycle count of first tx_valid after it.
  task automatic latency(input logic is_b, input int exp_cyc, input string tag);
    int cyc;
    cyc = 1;
    while (!(is_b ? b_tx_valid : a_tx_valid) && cyc < 200) begin
      if (cyc == 5) chk({tag, "_busy_div"}, is_b ? b_busy : a_busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_cyc);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_tx_valid", a_tx_valid, 1'b0);
    chk("rst_a_tx_data", a_tx_data, 8'h00);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_err", a_err, 1'b0);
    chk("rst_a_drop", a_drop, 1'b0);
    chk("rst_b_tx_valid", b_tx_valid, 1'b0);
    chk("rst_b_busy", b_busy, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic 1000 / 7
    send_a(16'd1000, 16'd7);
    latency(1'b0, 18, "basic");
    drain_a("basic");
    chk("basic_err", a_err, 1'b0);

    // Divide by zero, then next frame clears the flag on its first byte
    send_a(16'h1234, 16'h0000);
    drain_a("div0");
    chk("div0_err_set", a_err, 1'b1);
    push_a(16'h0009, 16'h0002);
    rx_a(8'h00);
    chk("div0_err_clear", a_err, 1'b0);
    rx_a(8'h09); rx_a(8'h00); rx_a(8'h02);
    drain_a("after_div0");

    // Timeout on a partial frame
    rx_a(8'h55); rx_a(8'h66);
    d0 = a_drops;
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("tmo_early", a_drop, 1'b0);
    @(posedge clk); #1;
    chk("tmo_pulse", a_drop, 1'b1);
    @(posedge clk); #1;
    chk("tmo_pulse_end", a_drop, 1'b0);
    chk("tmo_count", a_drops, d0 + 1);
    send_a(16'h0064, 16'h000A);
    drain_a("after_tmo");

    // Backpressure, random ready
    a_rdy_mode = 2;
    send_a(16'hFFFF, 16'h0010);
    drain_a("bp");
    a_rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] x, y;
      x = 16'($urandom); y = 16'($urandom_range(1, 300));
      a_rdy_mode = 2;
      send_a(x, y);
      drain_a("bp_rand");
    end
    a_rdy_mode = 0;
    @(posedge clk); #1;

    // Junk rx pulses during DIV and a stalled TX are ignored
    send_a(16'h1234, 16'h0056);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      rx_a(8'hA0 + 8'(i));
    end
    chk("ign_stalled_valid", a_tx_valid, 1'b1);
    a_rdy_mode = 1;
    drain_a("ignore");
    send_a(16'hBEEF, 16'h0123);
    drain_a("after_ignore");

    // Reset after the second tx byte
    send_a(16'h4321, 16'h0011);
    for (int i = 0; i < 200 && exp_a.size() != 2; i++) @(negedge clk);
    chk("rst_wait", exp_a.size(), 2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", a_tx_valid, 1'b0);
    chk("midrst_busy", a_busy, 1'b0);
    exp_a.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_a(16'h0ABC, 16'h0007);
    drain_a("after_rst");

    // 24-bit instance
    send_b(24'h010000, 24'h000003);
    latency(1'b1, 26, "w24");
    for (int i = 0; i < 200 && exp_b.size() != 0; i++) begin @(posedge clk); #1; end
    chk("w24_drain", exp_b.size(), 0);
    send_b(24'hABCDEF, 24'h00012F);
    for (int i = 0; i < 200 && exp_b.size() != 0; i++) begin @(posedge clk); #1; end
    chk("w24b_drain", exp_b.size(), 0);
    chk("w24_err", b_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_div_ctrl.md
Name: uart_div_ctrl

Overview:
- Frame-level controller between the UART receiver and transmitter.
- Collects a dividend and a divisor (each DATA_W bits) as a byte stream, MSB byte first.
- Runs a multi-cycle restoring divider, then streams quotient and remainder back, each MSB byte first.
- Parametrised in operand width, with a receive inter-byte timeout, divide-by-zero reporting and ready/valid backpressure on the transmit side.

Parameters:
- DATA_W, 16, operand width in bits; must be a multiple of 8 and at least 8. NB = DATA_W/8 bytes per operand.
- TIMEOUT_CYC, 416640, idle clk cycles allowed between receive bytes of one frame before the partial frame is discarded.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  transmitter can accept a byte this cycle.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  8  byte to send.
- busy  out  1  high in DIV and TX states.
- err_div0  out  1  last computed frame had divisor == 0.
- frame_drop  out  1  one-cycle pulse when a partial frame is discarded by timeout.

Behaviour:
- Reset values (async on rst low): tx_valid=0, tx_data=0, busy=0, err_div0=0, frame_drop=0. State=RX, byte count=0, timeout counter=0, operand registers=0.
- States: RX, DIV, TX. Reset mid-operation at any point returns to RX with an empty frame and no tx_valid. It takes effect immediately, without waiting for clk.
- RX state:
  - Each rx_valid pulse stores rx_data into the next byte slot. Bytes 0..NB-1 fill the dividend MSB first; bytes NB..2NB-1 fill the divisor MSB first.
  - When the first byte of a frame is accepted, err_div0 clears.
  - Timeout counter is reset by every accepted byte and increments each cycle while 1 <= byte count < 2NB. With byte count 0 it holds at 0.
  - When the counter reaches TIMEOUT_CYC-1, then on that clock edge: byte count goes to 0, frame_drop pulses for one cycle, operands are not cleared, and the state stays RX.
  - If rx_valid arrives in the same cycle as the timeout, the byte counts as byte 0 of a new frame.
  - Acceptance of byte 2NB-1 moves the state to DIV on the next cycle.
- DIV state:
  - Restoring division with a DATA_W+1 bit partial remainder. Exactly DATA_W cycles, one quotient bit per cycle, MSB first.
  - Each cycle: R = {R, next dividend bit}. If R >= divisor, then R -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - Divisor 0 is not special-cased in the datapath. It yields quotient = all ones and remainder = dividend.
  - err_div0 is set on DIV entry when divisor == 0 and held until the next frame's first byte.
  - After the last iteration the state moves to TX. tx_valid rises on the first TX cycle.
  - Latency: last rx_valid at cycle N gives tx_valid high at cycle N+DATA_W+2.
- TX state:
  - Sends 2NB bytes: quotient bytes MSB first, then remainder bytes MSB first.
  - tx_valid is held high and tx_data is held stable until a cycle with tx_ready=1. That cycle is the transfer.
  - The next byte is presented on the following cycle, with tx_valid continuously high between bytes.
  - After the transfer of the last byte, tx_valid=0 and the state returns to RX on the next cycle.
- rx_valid pulses in DIV or TX are ignored: no storage, no counter effect.
- busy = (state != RX), registered.

Test Plan:
- Basic divide, DATA_W=16: rx 03 E8 00 07 (1000/7) -> tx 00 8E 00 06, err_div0=0, first tx_valid exactly 18 cycles after the last rx_valid.
- Divide by zero: rx 12 34 00 00 -> tx FF FF 12 34, err_div0=1. The next frame rx 00 09 00 02 clears err_div0 on its first byte and returns 00 04 00 01.
- Timeout: rx 55 66, then idle TIMEOUT_CYC cycles -> frame_drop pulses once. Then rx 00 64 00 0A -> tx 00 0A 00 00.
- Backpressure: tx_ready random 30% high for frame 0xFFFF/0x0010 -> tx 0F FF 00 0F. tx_data stays stable while tx_valid=1 and tx_ready=0; no byte is lost or duplicated.
- Ignored input and reset: rx pulses during DIV/TX don't alter the output. Asserting rst after the second tx byte -> tx_valid=0 immediately, and a fresh frame then works.
- Width generalisation, DATA_W=24: rx 01 00 00 00 00 03 -> tx 00 55 55 00 00 01.
